// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and helpers for the serializer
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// rtl/serializer_bit_counter.sv - bit position counter with a saturating last flag
module bit_counter_m
    import serializer_pkg::*;
#(
    parameter int W = 8,
    localparam int CW = cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(W - 1));

    // Holds at W-1 so the count can never wrap into a new word by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serializer_m.sv
// rtl/serializer_m.sv - parallel-in serial-out transmitter with valid/ready input
module serializer_m
    import serializer_pkg::*;
#(
    parameter int W         = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW = cnt_width(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    output logic         din_rdy,
    input  logic         enb,
    output logic         sout,
    output logic         sout_vld,
    output logic         sout_first,
    output logic         sout_last,
    output logic         busy,
    output logic         done
);

    ser_state_t    state;
    logic [W-1:0]  shreg;
    logic [W-1:0]  shreg_next;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic          in_shift;
    logic          end_bit;
    logic          load;

    assign in_shift = (state == SHIFT);
    assign end_bit  = in_shift && cnt_last && enb;
    assign din_rdy  = !rst && ((state == IDLE) || end_bit);
    assign load     = din_rdy && din_vld;

    // Shift toward whichever end feeds sout, zero filling the vacated bit.
    assign shreg_next = (MSB_FIRST != 0) ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};

    bit_counter_m #(.W(W)) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .inc  (in_shift && enb && !cnt_last),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            done  <= 1'b0;
        end else begin
            done <= end_bit;
            if (load) begin
                shreg <= din;
                state <= SHIFT;
            end else if (end_bit) begin
                state <= IDLE;
            end else if (in_shift && enb) begin
                shreg <= shreg_next;
            end
        end
    end

    // Serial outputs are forced quiet while reset is asserted, even mid-word.
    assign sout_vld   = !rst && in_shift;
    assign busy       = sout_vld;
    assign sout       = sout_vld && ((MSB_FIRST != 0) ? shreg[W-1] : shreg[0]);
    assign sout_first = sout_vld && (cnt == '0);
    assign sout_last  = sout_vld && cnt_last;

endmodule
